// File: rtl/multi_tick_pkg.sv
// multi_tick_pkg: shared widths, cfg_ch sizing and per-channel state layout for multi_tick_gen
package multi_tick_pkg;
  localparam int CNT_W_DEFAULT = 32;
  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction
  typedef struct packed {
    logic [CNT_W_DEFAULT-1:0] div;
    logic [CNT_W_DEFAULT-1:0] div_pend;
    logic                     pend;
    logic [CNT_W_DEFAULT-1:0] cnt;
    logic                     sq;
    logic                     armed;
  } chan_state_t;
endpackage

// File: rtl/multi_tick_chan.sv
// multi_tick_chan: one divider channel with shadowed divisor; oneshot input present when MULTI_TICK_ONESHOT_EN is defined
module multi_tick_chan #(
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             restart,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
`ifdef MULTI_TICK_ONESHOT_EN
  input  logic             oneshot,
`endif
  output logic             sq,
  output logic             tick
);
  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
  logic [CNT_W-1:0] r_div, r_div_pend, r_cnt;
  logic r_pend, r_sq, r_tick, r_armed;
  logic w_os, w_wrap;
`ifdef MULTI_TICK_ONESHOT_EN
  assign w_os = oneshot;
`else
  assign w_os = 1'b0;
`endif
  assign w_wrap = enable && r_armed && (r_cnt == r_div - CNT_W'(1));
  // A write landing on a wrap stays pending; the wrap itself uses the older shadow.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_div      <= RST_DIV;
      r_div_pend <= RST_DIV;
      r_pend     <= 1'b0;
      r_cnt      <= '0;
      r_sq       <= 1'b0;
      r_tick     <= 1'b0;
      r_armed    <= 1'b1;
    end else if (restart) begin
      r_div      <= wr_en ? wr_div : (r_pend ? r_div_pend : r_div);
      if (wr_en) r_div_pend <= wr_div;
      r_pend     <= 1'b0;
      r_cnt      <= '0;
      r_sq       <= 1'b0;
      r_tick     <= 1'b0;
      r_armed    <= 1'b1;
    end else begin
      r_tick <= w_wrap && r_sq;
      if (enable && r_armed) r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      if (w_wrap) begin
        r_sq <= ~r_sq;
        if (r_sq && w_os) r_armed <= 1'b0;
        if (r_pend) r_div <= r_div_pend;
      end
      if (wr_en) begin
        r_div_pend <= wr_div;
        r_pend     <= 1'b1;
      end else if (w_wrap) r_pend <= 1'b0;
    end
  assign sq   = r_sq;
  assign tick = r_tick;
endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen: NCH programmable clock-enable channels with validated divisor writes;
// define MULTI_TICK_ONESHOT_EN to add the per-channel oneshot input.
module multi_tick_gen import multi_tick_pkg::*; #(
  parameter int          NCH         = 4,
  parameter int          CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 50_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NCH-1:0]        enable,
  input  logic [NCH-1:0]        restart,
`ifdef MULTI_TICK_ONESHOT_EN
  input  logic [NCH-1:0]        oneshot,
`endif
  input  logic                  cfg_we,
  input  logic [ch_w(NCH)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]      cfg_div,
  output logic                  cfg_err,
  output logic [NCH-1:0]        sq,
  output logic [NCH-1:0]        tick
);
  localparam int CHW = ch_w(NCH);
  logic w_ok, r_cfg_err;
  assign w_ok = cfg_we && (cfg_div != '0) && (32'(cfg_ch) < NCH);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_cfg_err <= 1'b0;
    else r_cfg_err <= cfg_we && !w_ok;
  assign cfg_err = r_cfg_err;
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    multi_tick_chan #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable[g]),
      .restart (restart[g]),
      .wr_en   (w_ok && (cfg_ch == CHW'(g))),
      .wr_div  (cfg_div),
`ifdef MULTI_TICK_ONESHOT_EN
      .oneshot (oneshot[g]),
`endif
      .sq      (sq[g]),
      .tick    (tick[g])
    );
  end
endmodule
